// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode 7-segment display.
// Optional build macro LEADING_ZERO_BLANK_EN keeps leading-zero digits dark.
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic                    w,
    output logic                    x,
    output logic                    y,
    output logic                    z,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    frame_done,
    output logic [1:0]              o_dbg_state
);

    localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_DIGITS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;
    // With no guard interval a digit goes straight from one SHOW to the next.
    localparam logic [1:0] S_FIRST = (BLANK_CYCLES == 0) ? S_SHOW : S_BLANK;

    localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [1:0]              r_state;
    logic [IW-1:0]           r_idx;
    logic [CW-1:0]           r_cnt;
    logic [4*NUM_DIGITS-1:0] r_pend_nib;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_dirty;
    logic [4*NUM_DIGITS-1:0] r_act_nib;
    logic [NUM_DIGITS-1:0]   r_act_dp;

    logic [1:0]              w_state_nx;
    logic [IW-1:0]           w_idx_nx;
    logic [CW-1:0]           w_cnt_nx;
    logic                    w_wrap;
    logic [4*NUM_DIGITS-1:0] w_act_nib_nx;
    logic [NUM_DIGITS-1:0]   w_act_dp_nx;
    logic [NUM_DIGITS-1:0]   w_lz_mask;
    logic [NUM_DIGITS-1:0]   w_sel_nx;
    logic [3:0]              w_nib_nx;
    logic                    w_dp_nx;

    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_cnt_nx   = r_cnt;
        w_wrap     = 1'b0;
        if (!en) begin
            w_state_nx = S_IDLE;
            w_idx_nx   = '0;
            w_cnt_nx   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_FIRST;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                end
                S_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        w_state_nx = S_SHOW;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_state_nx = S_FIRST;
                        w_cnt_nx   = '0;
                        if (r_idx == IDX_LAST) begin
                            w_idx_nx = '0;
                            w_wrap   = 1'b1;
                        end else begin
                            w_idx_nx = r_idx + 1'b1;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_idx_nx   = '0;
                    w_cnt_nx   = '0;
                end
            endcase
        end
    end

    // Active buffer only changes on the frame boundary; a load landing on that
    // very edge bypasses pending so it is not deferred by a whole frame.
    always_comb begin
        w_act_nib_nx = r_act_nib;
        w_act_dp_nx  = r_act_dp;
        if (w_wrap) begin
            if (load) begin
                w_act_nib_nx = din;
                w_act_dp_nx  = dp_in;
            end else if (r_dirty) begin
                w_act_nib_nx = r_pend_nib;
                w_act_dp_nx  = r_pend_dp;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_lz_mask    = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_upper_zero = v_upper_zero && (w_act_nib_nx[4*k +: 4] == 4'h0);
            w_lz_mask[k] = (k == 0) || !v_upper_zero;
        end
    end
`else
    assign w_lz_mask = '1;
`endif

    // Outputs are derived from next-state values so the registered pins line up
    // with the state they describe.
    always_comb begin
        w_nib_nx = w_act_nib_nx[{w_idx_nx, 2'b00} +: 4];
        w_dp_nx  = w_act_dp_nx[w_idx_nx];
        w_sel_nx = '0;
        if (w_state_nx == S_SHOW) begin
            w_sel_nx = (NUM_DIGITS'(1) << w_idx_nx) & w_lz_mask;
        end
        if (w_state_nx == S_IDLE) begin
            w_nib_nx = 4'h0;
            w_dp_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_pend_nib <= '0;
            r_pend_dp  <= '0;
            r_dirty    <= 1'b0;
            r_act_nib  <= '0;
            r_act_dp   <= '0;
            {w, x, y, z} <= 4'h0;
            dp         <= 1'b0;
            digit_sel  <= '0;
            frame_done <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_idx     <= w_idx_nx;
            r_cnt     <= w_cnt_nx;
            r_act_nib <= w_act_nib_nx;
            r_act_dp  <= w_act_dp_nx;
            if (load) begin
                r_pend_nib <= din;
                r_pend_dp  <= dp_in;
            end
            if (w_wrap) begin
                r_dirty <= 1'b0;
            end else if (load) begin
                r_dirty <= 1'b1;
            end
            {w, x, y, z} <= w_nib_nx;
            dp         <= w_dp_nx;
            digit_sel  <= w_sel_nx;
            frame_done <= w_wrap;
        end
    end

    assign o_dbg_state = r_state;

endmodule
